// File: rtl/md_issue_ctrl.sv
// md_issue_ctrl: processor-side issue/stall/writeback controller for the multdiv unit.
// Ports:
//   clock_i, reset_i             clock, synchronous active-high reset
//   ex_valid_i, ex_is_mult_i,    execute-stage mult/div request with operands
//   ex_is_div_i, ex_opA_i,       and destination register
//   ex_opB_i, ex_rd_i
//   flush_i                      squash the in-flight op
//   md_result_i, md_exception_i, multdiv result, exception and ready
//   md_ready_i
//   md_ctrl_mult_o, md_ctrl_div_o  one-cycle start pulses
//   md_opA_o, md_opB_o           latched operands, held until the next accept
//   stall_o                      freeze PC and upstream latches
//   wb_valid_o, wb_rd_o,         one-cycle register-file write
//   wb_data_o
//   md_timeout_o                 one-cycle pulse on a hung-unit abort
module md_issue_ctrl #(
    parameter int unsigned RSTATUS_REG   = 30,
    parameter int unsigned MULT_EXC_CODE = 4,
    parameter int unsigned DIV_EXC_CODE  = 5,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        ex_valid_i,
    input  logic        ex_is_mult_i,
    input  logic        ex_is_div_i,
    input  logic [31:0] ex_opA_i,
    input  logic [31:0] ex_opB_i,
    input  logic [4:0]  ex_rd_i,
    input  logic        flush_i,
    input  logic [31:0] md_result_i,
    input  logic        md_exception_i,
    input  logic        md_ready_i,
    output logic        md_ctrl_mult_o,
    output logic        md_ctrl_div_o,
    output logic [31:0] md_opA_o,
    output logic [31:0] md_opB_o,
    output logic        stall_o,
    output logic        wb_valid_o,
    output logic [4:0]  wb_rd_o,
    output logic [31:0] wb_data_o,
    output logic        md_timeout_o
);
    localparam int CW = $clog2(TIMEOUT);
    typedef enum logic [2:0] {IDLE, ISSUE, WAIT, WB, DRAIN} state_e;
    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic [31:0]   opa_q, opb_q, wb_data_q;
    logic [4:0]    rd_q, wb_rd_q;
    logic          kind_q, ctrl_mult_q, ctrl_div_q, wb_valid_q, timeout_q;
    logic          md_req, cnt_last;
    logic [31:0]   exc_data;
    assign md_req   = ex_valid_i & (ex_is_mult_i | ex_is_div_i);
    assign cnt_last = cnt_q == CW'(TIMEOUT - 1);
    assign exc_data = kind_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);
    // Stall covers the accept cycle combinationally; in DRAIN only a new mult/div is held back.
    assign stall_o = ~reset_i & ((state_q == ISSUE) | (state_q == WAIT) |
                                 (((state_q == IDLE) | (state_q == DRAIN)) & md_req));
    // Registered pulses are also gated by reset so they drop in the reset cycle itself.
    assign md_ctrl_mult_o = ctrl_mult_q & ~reset_i;
    assign md_ctrl_div_o  = ctrl_div_q & ~reset_i;
    assign wb_valid_o     = wb_valid_q & ~reset_i;
    assign md_timeout_o   = timeout_q & ~reset_i;
    assign wb_rd_o        = wb_rd_q;
    assign wb_data_o      = wb_data_q;
    assign md_opA_o       = opa_q;
    assign md_opB_o       = opb_q;
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            opa_q       <= '0;
            opb_q       <= '0;
            rd_q        <= '0;
            kind_q      <= 1'b0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
        end else begin
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= '0;
            wb_data_q   <= '0;
            timeout_q   <= 1'b0;
            case (state_q)
                IDLE: if (md_req) begin
                    opa_q       <= ex_opA_i;
                    opb_q       <= ex_opB_i;
                    rd_q        <= ex_rd_i;
                    kind_q      <= ~ex_is_mult_i;
                    ctrl_mult_q <= ex_is_mult_i;
                    ctrl_div_q  <= ~ex_is_mult_i;
                    state_q     <= ISSUE;
                end
                // Ready seen here is left over from the previous op and is ignored.
                ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= flush_i ? DRAIN : WAIT;
                end
                WAIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (flush_i) begin
                        cnt_q   <= '0;
                        state_q <= DRAIN;
                    end else if (md_ready_i) begin
                        wb_valid_q <= md_exception_i | (rd_q != 5'd0);
                        wb_rd_q    <= md_exception_i ? 5'(RSTATUS_REG) : rd_q;
                        wb_data_q  <= md_exception_i ? exc_data : md_result_i;
                        state_q    <= WB;
                    end else if (cnt_last) begin
                        wb_valid_q <= 1'b1;
                        wb_rd_q    <= 5'(RSTATUS_REG);
                        wb_data_q  <= exc_data;
                        timeout_q  <= 1'b1;
                        state_q    <= WB;
                    end
                end
                WB: state_q <= IDLE;
                // cnt_q==0 marks the first DRAIN cycle, where ready may still be stale.
                DRAIN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (md_ready_i && cnt_q != '0) begin
                        state_q <= IDLE;
                    end else if (cnt_last) begin
                        timeout_q <= 1'b1;
                        state_q   <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_md_issue_ctrl.sv
// tb_md_issue_ctrl: randomized scoreboard bench for md_issue_ctrl with a behavioural multdiv model.
module tb_md_issue_ctrl;
    localparam int TO = 64;
    typedef struct {logic [4:0] rd; logic [31:0] data;} wb_t;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst, ex_valid, ex_is_mult, ex_is_div, flush, md_exception, md_ready;
    logic [31:0] ex_opa, ex_opb, md_result;
    logic [4:0]  ex_rd;
    logic        ctrl_m, ctrl_d, stall, wb_valid, md_to;
    logic [31:0] opa_o, opb_o, wb_data;
    logic [4:0]  wb_rd;
    md_issue_ctrl dut (
        .clock_i(clk), .reset_i(rst), .ex_valid_i(ex_valid), .ex_is_mult_i(ex_is_mult),
        .ex_is_div_i(ex_is_div), .ex_opA_i(ex_opa), .ex_opB_i(ex_opb), .ex_rd_i(ex_rd),
        .flush_i(flush), .md_result_i(md_result), .md_exception_i(md_exception),
        .md_ready_i(md_ready), .md_ctrl_mult_o(ctrl_m), .md_ctrl_div_o(ctrl_d),
        .md_opA_o(opa_o), .md_opB_o(opb_o), .stall_o(stall), .wb_valid_o(wb_valid),
        .wb_rd_o(wb_rd), .wb_data_o(wb_data), .md_timeout_o(md_to)
    );
    wb_t  exp_q[$];
    wb_t  got;
    int   checks = 0, errors = 0, cyc = 0, pulses = 0, to_seen = 0, exp_to = 0;
    int   lat_cur = 1, unit_due = -1;
    logic [31:0] unit_res;
    logic        unit_exc;
    bit          pulse_prev = 0;
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    // Arithmetic the multdiv unit is expected to produce.
    function automatic void calc(input bit is_div, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] r, output logic e);
        longint p;
        int sa, sb;
        sa = a;
        sb = b;
        if (!is_div) begin
            p = longint'(sa) * longint'(sb);
            r = p[31:0];
            e = p != longint'(int'(p[31:0]));
        end else begin
            e = b == 0;
            r = e ? 32'd0 : 32'(sa / sb);
        end
    endfunction
    always @(posedge clk) cyc++;
    // Multdiv model: on a pulse, drop ready next cycle and raise it lat_cur cycles after the pulse.
    always @(negedge clk) begin
        if (ctrl_m | ctrl_d) begin
            pulses++;
            check("pulse_exclusive", ctrl_m & ctrl_d, 0);
            calc(ctrl_d, opa_o, opb_o, unit_res, unit_exc);
            unit_due   = cyc + lat_cur;
            pulse_prev = 1;
        end
    end
    always @(posedge clk) begin
        #1;
        if (pulse_prev) begin
            md_ready     = 1'b0;
            md_result    = $urandom;
            md_exception = 1'b0;
            pulse_prev   = 0;
        end
        if (cyc == unit_due) begin
            md_ready     = 1'b1;
            md_result    = unit_res;
            md_exception = unit_exc;
        end
    end
    // Scoreboard monitor.
    always @(negedge clk) begin
        if (wb_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wb_unexpected: got r%0d=%0h expected no writeback", wb_rd, wb_data);
            end else begin
                got = exp_q.pop_front();
                check("wb_rd", wb_rd, got.rd);
                check("wb_data", wb_data, got.data);
            end
        end
        if (md_to) begin
            to_seen++;
            check("timeout_with_wb", {wb_valid, wb_rd}, {1'b1, 5'd30});
        end
    end
    task automatic clear_ex();
        ex_valid = 0; ex_is_mult = 0; ex_is_div = 0; flush = 0;
    endtask
    // Present one op in EX, hold it while stalled, optionally flush; expectations pushed up front.
    task automatic run_op(input bit is_div, input bit both, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input int lat, input int flush_at,
                          input bit wb_flush, input bit chk_stall);
        logic [31:0] r;
        logic e;
        int p0, nstall, pc, w;
        bit kd, done;
        kd = is_div & ~both;
        w = lat > TO ? TO : lat;
        calc(kd, a, b, r, e);
        if (flush_at < 0) begin
            if (lat > TO) begin
                exp_q.push_back('{5'd30, kd ? 32'd5 : 32'd4});
                exp_to++;
            end else if (e) exp_q.push_back('{5'd30, kd ? 32'd5 : 32'd4});
            else if (rd != 0) exp_q.push_back('{rd, r});
        end
        lat_cur = lat; p0 = pulses; nstall = 0; pc = -1; done = 0;
        ex_valid = 1; ex_is_mult = !is_div | both; ex_is_div = is_div | both;
        ex_opa = a; ex_opb = b; ex_rd = rd;
        for (int i = 0; i < 300 && !done; i++) begin
            @(negedge clk);
            if (!stall) done = 1;
            else begin
                nstall++;
                @(posedge clk); #1;
                if (ctrl_m | ctrl_d) pc = cyc;
                flush = (flush_at >= 0 && pc >= 0 && cyc == pc + flush_at) ||
                        (wb_flush && pc >= 0 && cyc == pc + w + 1);
                if (flush_at >= 0 && flush) begin
                    @(posedge clk); #1;
                    clear_ex();
                    check("pulse_count_flushed", pulses - p0, 1);
                    return;
                end
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL op_bound: got stall still high after 300 cycles expected release");
        end
        if (chk_stall) check("stall_cycles", nstall, 2 + w);
        check("pulse_count", pulses - p0, 1);
        @(posedge clk); #1;
        clear_ex();
    endtask
    task automatic gap(input bit idle_flush);
        flush = idle_flush;
        @(negedge clk);
        check("stall_gap", stall, 0);
        @(posedge clk); #1;
        flush = 0;
    endtask
    initial begin
        bit prev_fl;
        logic [31:0] a, b;
        int lat, fa;
        bit dv;
        rst = 1; clear_ex(); ex_opa = 0; ex_opb = 0; ex_rd = 0;
        md_ready = 0; md_result = 0; md_exception = 0;
        ex_valid = 1; ex_is_mult = 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ctrl", {ctrl_m, ctrl_d, stall, wb_valid, md_to}, 0);
        check("rst_data", {wb_rd, wb_data, opa_o}, 0);
        check("rst_opb", opb_o, 0);
        @(posedge clk); #1;
        rst = 0; clear_ex();
        gap(0);
        run_op(0, 0, 7, -3, 5, 33, -1, 0, 1);
        gap(0);
        run_op(1, 0, 100, 0, 8, 5, -1, 0, 1);
        gap(1);
        run_op(0, 0, 32'h4000_0000, 4, 3, 10, -1, 0, 1);
        gap(0);
        run_op(1, 0, 9, 2, 0, 6, -1, 0, 1);
        gap(0);
        run_op(0, 0, 12, 12, 7, 1, -1, 1, 1);
        gap(0);
        run_op(1, 1, 6, 5, 9, 4, -1, 0, 1);
        gap(0);
        run_op(1, 0, -77, 7, 11, 64, -1, 0, 1);
        gap(0);
        run_op(0, 0, 3, 3, 12, 65, -1, 0, 1);
        gap(0);
        run_op(1, 0, 5, 1, 13, 1000, -1, 0, 1);
        gap(0);
        run_op(1, 0, 50, 7, 9, 20, 3, 0, 1);
        run_op(0, 0, 6, 7, 4, 8, -1, 0, 0);
        gap(0);
        run_op(0, 0, 2, 9, 14, 12, 0, 0, 1);
        run_op(1, 0, 81, 9, 15, 3, -1, 0, 0);
        gap(0);
        // Reset in the middle of WAIT: no writeback, outputs drop, latches clear.
        lat_cur = 1000;
        ex_valid = 1; ex_is_mult = 1; ex_opa = 33; ex_opb = 44; ex_rd = 6;
        repeat (10) @(posedge clk);
        #1 rst = 1;
        @(negedge clk);
        check("rst_mid_stall", {stall, wb_valid, ctrl_m, ctrl_d}, 0);
        @(posedge clk); #1;
        rst = 0; clear_ex();
        @(negedge clk);
        check("rst_mid_latch", {opa_o, opb_o}, 0);
        @(posedge clk); #1;
        prev_fl = 0;
        for (int n = 0; n < 40; n++) begin
            dv = $urandom % 2;
            a = $urandom;
            b = ($urandom % 2) ? $urandom : $urandom_range(0, 1000);
            if (dv && $urandom % 6 == 0) b = 0;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) b = 1;
            lat = $urandom_range(1, 40);
            fa = ($urandom % 4 == 0) ? $urandom_range(0, lat - 1) : -1;
            if (!prev_fl) gap(($urandom % 3) == 0);
            run_op(dv, $urandom % 8 == 0, a, b, 5'($urandom), lat, fa,
                   fa < 0 && $urandom % 4 == 0, !prev_fl);
            prev_fl = fa >= 0;
        end
        repeat (80) @(posedge clk);
        check("sb_empty", exp_q.size(), 0);
        check("timeout_count", to_seen, exp_to);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
